// File: rtl/image_frame_driver_pkg.sv
// Shared types and default frame geometry for the image frame driver and the
// per-pixel processing blocks it feeds.
package img_pkg;

  localparam int DEF_WIDTH  = 410;
  localparam int DEF_HEIGHT = 361;

  typedef logic [7:0] pixel_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    GAP   = 3'd2,
    PROC  = 3'd3,
    DRAIN = 3'd4,
    DONE  = 3'd5
  } state_e;

endpackage

// File: rtl/image_frame_driver_if.sv
// Bus between the frame driver and its source ROM, processing block and result RAM.
// master = driver side, slave = memory/processing side.
interface image_frame_driver_if #(
  parameter int AW = 18
);
  import img_pkg::*;

  logic [AW-1:0] src_addr;
  pixel_t        src_data;
  pixel_t        dut_pixel;
  logic          dut_enable;
  logic          dut_enable_proc;
  logic          dut_do_bright;
  pixel_t        dut_bright;
  pixel_t        dut_pixel_in;
  logic          dut_finish;
  logic [AW-1:0] res_addr;
  pixel_t        res_data;
  logic          res_we;

  modport master (
    output src_addr, dut_pixel, dut_enable, dut_enable_proc, dut_do_bright,
           dut_bright, res_addr, res_data, res_we,
    input  src_data, dut_pixel_in, dut_finish
  );

  modport slave (
    input  src_addr, dut_pixel, dut_enable, dut_enable_proc, dut_do_bright,
           dut_bright, res_addr, res_data, res_we,
    output src_data, dut_pixel_in, dut_finish
  );

endinterface

// File: rtl/image_frame_driver_counter.sv
// AW-bit pixel counter that wraps to 0 after TOTAL-1; last_o flags the final pixel.
module frame_counter
  import img_pkg::*;
#(
  parameter int AW    = 18,
  parameter int TOTAL = DEF_WIDTH * DEF_HEIGHT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          inc_i,
  output logic [AW-1:0] cnt_o,
  output logic          last_o
);

  localparam logic [AW-1:0] LAST = AW'(TOTAL - 1);

  logic [AW-1:0] cnt_q;
  logic [AW-1:0] cnt_d;

  // Clear wins over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      if (cnt_q == LAST) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + AW'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign last_o = (cnt_q == LAST);

endmodule

// File: rtl/image_frame_driver.sv
// Frame master: loads a raster frame from ROM into a pixel block, runs its process
// phase and writes results to RAM. FRAME_CHECKSUM_EN adds a 32-bit pixel-sum output.
module image_frame_driver
  import img_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT,
  parameter int AW     = 18
) (
  input  logic                 clk,
  input  logic                 rst_n,
  image_frame_driver_if.master bus,
  input  logic                 start,
  input  logic                 mode_in,
  input  pixel_t               level_in,
  output logic                 busy,
  output logic                 done,
  output logic                 err
`ifdef FRAME_CHECKSUM_EN
  ,
  output logic [31:0]          checksum
`endif
);

  localparam int TOTAL = WIDTH * HEIGHT;

  state_e        state_q, state_d;
  logic [AW-1:0] ld_cnt, cap_cnt;
  logic          ld_last, cap_last;
  logic          accept, ld_inc;

  logic   wrapped_q, wrapped_d;
  logic   en_q, en_d;
  logic   proc_q, proc_d;
  logic   we_q, we_d;
  logic   busy_q, busy_d;
  logic   done_q, done_d;
  logic   err_q, err_d;
  logic   mode_q, mode_d;
  pixel_t level_q, level_d;

  assign accept = (state_q == IDLE) && start;
  // One counter walks ROM addresses in LOAD, then times the proc strobes in PROC.
  assign ld_inc = ((state_q == LOAD) && !wrapped_q) || (state_q == PROC);

  frame_counter #(.AW(AW), .TOTAL(TOTAL)) u_ld_cnt (
    .clk(clk), .rst_n(rst_n), .clr_i(accept), .inc_i(ld_inc),
    .cnt_o(ld_cnt), .last_o(ld_last)
  );

  frame_counter #(.AW(AW), .TOTAL(TOTAL)) u_cap_cnt (
    .clk(clk), .rst_n(rst_n), .clr_i(accept), .inc_i(we_q),
    .cnt_o(cap_cnt), .last_o(cap_last)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start     ? LOAD  : IDLE;
      LOAD:    state_d = wrapped_q ? GAP   : LOAD;
      GAP:     state_d = PROC;
      PROC:    state_d = ld_last   ? DRAIN : PROC;
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output/next-value logic; outputs are registered, so they follow state_d.
  always_comb begin
    en_d      = (state_q == LOAD) && !wrapped_q;
    proc_d    = (state_d == PROC);
    we_d      = proc_q;
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DONE);
    mode_d    = mode_q;
    level_d   = level_q;
    err_d     = err_q;
    wrapped_d = wrapped_q;
    if (accept) begin
      mode_d    = mode_in;
      level_d   = level_in;
      err_d     = 1'b0;
      wrapped_d = 1'b0;
    end else begin
      // Finish must be high exactly on the last capture.
      if (we_q && (bus.dut_finish != cap_last)) begin
        err_d = 1'b1;
      end else begin
        err_d = err_q;
      end
      if ((state_q == LOAD) && ld_inc && ld_last) begin
        wrapped_d = 1'b1;
      end else begin
        wrapped_d = wrapped_q;
      end
    end
  end

  // Output and control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrapped_q <= 1'b0;
      en_q      <= 1'b0;
      proc_q    <= 1'b0;
      we_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      mode_q    <= 1'b0;
      level_q   <= 8'd0;
    end else begin
      wrapped_q <= wrapped_d;
      en_q      <= en_d;
      proc_q    <= proc_d;
      we_q      <= we_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      mode_q    <= mode_d;
      level_q   <= level_d;
    end
  end

`ifdef FRAME_CHECKSUM_EN
  logic [31:0] sum_q, sum_d;

  // Running sum of captured pixels.
  always_comb begin
    if (accept) begin
      sum_d = 32'd0;
    end else if (we_q) begin
      sum_d = sum_q + 32'(bus.dut_pixel_in);
    end else begin
      sum_d = sum_q;
    end
  end

  // Checksum register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= 32'd0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign checksum = sum_q;
`endif

  // ROM data and returned pixels pass straight through, gated by their strobes.
  assign bus.src_addr        = ld_cnt;
  assign bus.dut_pixel       = en_q ? bus.src_data : 8'd0;
  assign bus.dut_enable      = en_q;
  assign bus.dut_enable_proc = proc_q;
  assign bus.dut_do_bright   = mode_q;
  assign bus.dut_bright      = level_q;
  assign bus.res_addr        = cap_cnt;
  assign bus.res_data        = we_q ? bus.dut_pixel_in : 8'd0;
  assign bus.res_we          = we_q;
  assign busy                = busy_q;
  assign done                = done_q;
  assign err                 = err_q;

endmodule

// File: tb/tb_image_frame_driver.sv
// Scoreboard bench for image_frame_driver on a 4x5 frame with a behavioural
// brightness block; define FRAME_CHECKSUM_EN to also check the checksum port.
module tb_image_frame_driver;
  import img_pkg::*;

  localparam int W = 4, H = 5, AW = 5, TOTAL = 20;

  typedef struct {
    logic        err;
    logic [31:0] sum;
  } frame_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       mode_in = 1'b0;
  logic [7:0] level_in = 8'd0;
  logic       busy, done, err;
`ifdef FRAME_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  int total = 0;
  int bad = 0;

  image_frame_driver_if #(.AW(AW)) bus ();

  image_frame_driver #(.WIDTH(W), .HEIGHT(H), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .start(start), .mode_in(mode_in),
    .level_in(level_in), .busy(busy), .done(done), .err(err)
`ifdef FRAME_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  // Source ROM, 1-cycle read latency
  logic [7:0] rom [0:31];
  always @(posedge clk) bus.src_data <= rom[bus.src_addr];

  function automatic logic [7:0] bright(input logic m, input logic [7:0] lv, input logic [7:0] p);
    int s;
    if (m) s = int'(p) + int'(lv);
    else   s = int'(p) - int'(lv);
    if (s > 255) s = 255;
    if (s < 0)   s = 0;
    return s[7:0];
  endfunction

  // Behavioural processing block (no reset)
  logic [7:0] mbuf [0:TOTAL-1];
  int m_ld = 0, m_pr = 0, fin_at = 19;
  always @(posedge clk) begin
    if (bus.dut_enable) begin
      mbuf[m_ld] <= bus.dut_pixel;
      m_ld <= (m_ld == TOTAL-1) ? 0 : m_ld + 1;
    end
    if (bus.dut_enable_proc) begin
      bus.dut_pixel_in <= bright(bus.dut_do_bright, bus.dut_bright, mbuf[m_pr]);
      bus.dut_finish   <= (m_pr == fin_at);
      m_pr <= (m_pr == TOTAL-1) ? 0 : m_pr + 1;
    end
  end

  logic [7:0]  q_pix [$];
  logic [12:0] q_wr  [$];
  frame_t      q_frm [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: got event with nothing expected or bound expired (t=%0t)", name, $time);
  endtask

  // Monitor: pops expected values whenever the DUT presents a strobe
  int cyc = 0, last_en_cyc = 0, en_cnt = 0, proc_cnt = 0, wr_cnt = 0, done_cnt = 0;
  logic prev_en = 1'b0, prev_proc = 1'b0;
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      check("reset_outputs_zero",
            {bus.src_addr, bus.dut_pixel, bus.dut_enable, bus.dut_enable_proc, bus.dut_do_bright,
             bus.dut_bright, bus.res_addr, bus.res_data, bus.res_we, busy, done, err}, 64'd0);
`ifdef FRAME_CHECKSUM_EN
      check("reset_checksum", checksum, 64'd0);
`endif
      q_pix.delete(); q_wr.delete(); q_frm.delete();
      en_cnt = 0; proc_cnt = 0; wr_cnt = 0; prev_en = 1'b0; prev_proc = 1'b0;
    end else begin
      if (bus.dut_enable || bus.dut_enable_proc)
        check("strobe_exclusive", bus.dut_enable & bus.dut_enable_proc, 64'd0);
      if (bus.dut_enable) begin
        if (q_pix.size() == 0) fail_now("unexpected_enable");
        else check("dut_pixel", bus.dut_pixel, q_pix.pop_front());
        if (en_cnt > 0) check("enable_consecutive", prev_en, 64'd1);
        en_cnt++;
        last_en_cyc = cyc;
      end
      if (bus.dut_enable_proc && !prev_proc) check("gap_cycles", cyc - last_en_cyc, 64'd2);
      if (bus.dut_enable_proc) proc_cnt++;
      if (bus.res_we) begin
        if (q_wr.size() == 0) fail_now("unexpected_write");
        else check("res_addr_data", {bus.res_addr, bus.res_data}, q_wr.pop_front());
        wr_cnt++;
      end
      if (done) begin
        done_cnt++;
        if (q_frm.size() == 0) fail_now("unexpected_done");
        else begin
          frame_t f;
          f = q_frm.pop_front();
          check("frame_err", err, f.err);
          check("enable_count", en_cnt, 64'd20);
          check("proc_count", proc_cnt, 64'd20);
          check("write_count", wr_cnt, 64'd20);
`ifdef FRAME_CHECKSUM_EN
          check("checksum", checksum, f.sum);
`endif
        end
        en_cnt = 0; proc_cnt = 0; wr_cnt = 0;
      end
      prev_en = bus.dut_enable;
      prev_proc = bus.dut_enable_proc;
    end
  end

  task automatic push_frame(input logic m, input logic [7:0] lv, input logic e, input logic [31:0] s);
    for (int a = 0; a < TOTAL; a++) begin
      q_pix.push_back(8'(a * 10));
      q_wr.push_back({5'(a), bright(m, lv, 8'(a * 10))});
    end
    q_frm.push_back('{err: e, sum: s});
  endtask

  task automatic pulse_start(input logic m, input logic [7:0] lv);
    mode_in = m; level_in = lv; start = 1'b1;
    @(negedge clk);
    start = 1'b0; mode_in = ~m; level_in = 8'hA5;
    check("start_busy", busy, 64'd1);
    check("start_clears_err", err, 64'd0);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 200) begin @(negedge clk); n++; end
    if (!done) fail_now("timeout_done");
  endtask

  task automatic run_frame(input logic m, input logic [7:0] lv, input int fa, input logic e, input logic [31:0] s);
    fin_at = fa;
    push_frame(m, lv, e, s);
    pulse_start(m, lv);
    wait_done();
    @(negedge clk);
    check("busy_low_after_done", busy, 64'd0);
  endtask

  initial begin
    int n;
    int dc;
    for (int a = 0; a < 32; a++) rom[a] = (a < TOTAL) ? 8'(a * 10) : 8'd0;

    // 1: start toggled under reset is ignored
    repeat (2) @(negedge clk);
    start = 1'b1; @(negedge clk); start = 1'b0; @(negedge clk);
    start = 1'b1; @(negedge clk);
    check("reset_busy", busy, 64'd0);
    start = 1'b0; @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_busy", busy, 64'd0);

    // 2-4: brighten, darken with clipping, early finish
    run_frame(1'b1, 8'd10, 19, 1'b0, 32'd2100);
    run_frame(1'b0, 8'd50, 19, 1'b0, 32'd1050);
    run_frame(1'b1, 8'd10, 9, 1'b1, 32'd2100);

    // 5: missing finish; start in PROC and DONE ignored, accepted right after DONE
    fin_at = -1;
    push_frame(1'b0, 8'd50, 1'b1, 32'd1050);
    pulse_start(1'b0, 8'd50);
    n = 0;
    while (!bus.dut_enable_proc && n < 100) begin @(negedge clk); n++; end
    if (!bus.dut_enable_proc) fail_now("timeout_proc");
    start = 1'b1; @(negedge clk); start = 1'b0;
    wait_done();
    push_frame(1'b1, 8'd10, 1'b0, 32'd2100);
    mode_in = 1'b1; level_in = 8'd10; start = 1'b1;
    @(negedge clk);
    check("start_in_done_ignored", busy, 64'd0);
    @(negedge clk);
    start = 1'b0;
    check("start_after_done_accepted", busy, 64'd1);
    check("err_cleared_on_start", err, 64'd0);
    fin_at = 19;

    // 6: reset during PROC cycle 7
    dc = done_cnt;
    n = 0;
    while (!bus.dut_enable_proc && n < 100) begin @(negedge clk); n++; end
    if (!bus.dut_enable_proc) fail_now("timeout_proc6");
    repeat (7) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_proc_low", bus.dut_enable_proc, 64'd0);
    check("async_we_low", bus.res_we, 64'd0);
    check("async_busy_low", busy, 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    check("no_done_after_reset", done_cnt, dc);
    check("idle_after_reset", busy, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
